// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble execute stage: widths, opcodes, FSM states
// and the branch-condition helpers used by the PC control logic.
package nibble_pkg;

  localparam int DW_DEFAULT = 4;
  localparam int AW_DEFAULT = 12;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LIT  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_CMP  = 4'd6;
  localparam logic [3:0] OP_JC   = 4'd7;
  localparam logic [3:0] OP_JNC  = 4'd8;
  localparam logic [3:0] OP_JZ   = 4'd9;
  localparam logic [3:0] OP_JNZ  = 4'd10;
  localparam logic [3:0] OP_JMP  = 4'd11;
  localparam logic [3:0] OP_OUT  = 4'd12;
  localparam logic [3:0] OP_IN   = 4'd13;
  localparam logic [3:0] OP_HALT = 4'd14;
  localparam logic [3:0] OP_NOP2 = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_EXEC     = 3'd1,
    S_WAIT_IN  = 3'd2,
    S_WAIT_OUT = 3'd3,
    S_HALT     = 3'd4
  } state_e;

  function automatic logic is_jump(input logic [3:0] op);
    return (op >= OP_JC) && (op <= OP_JMP);
  endfunction

  function automatic logic jump_taken(input logic [3:0] op, input logic c, input logic z);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_JC:   taken = c;
      OP_JNC:  taken = !c;
      OP_JZ:   taken = z;
      OP_JNZ:  taken = !z;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/nibble_exec_if.sv
// Input and output nibble streams of the execute stage, each a valid/ready pair.
interface nibble_exec_if #(
  parameter int DW = nibble_pkg::DW_DEFAULT
) ();

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  // master is the environment (source of input nibbles, sink of output nibbles)
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/nibble_alu.sv
// Combinational ALU for the nibble ISA: produces the next accumulator value and
// the next C/Z flags for the data-processing opcodes; other opcodes pass through.
module nibble_alu
  import nibble_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] op,
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] k,
  input  logic          c,
  input  logic          z,
  output logic [DW-1:0] result,
  output logic          c_next,
  output logic          z_next,
  output logic          wr_acc
);

  logic [DW:0]   sum;
  logic [DW-1:0] diff;
  logic [DW-1:0] and_r;
  logic [DW-1:0] nor_r;

  assign sum   = {1'b0, acc} + {1'b0, k};
  assign diff  = acc - k;
  assign and_r = acc & k;
  assign nor_r = ~(acc | k);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    result = acc;
    c_next = c;
    z_next = z;
    wr_acc = 1'b0;
    case (op)
      OP_LIT: begin
        result = k;
        wr_acc = 1'b1;
      end
      OP_ADD: begin
        result = sum[DW-1:0];
        c_next = sum[DW];
        z_next = (sum[DW-1:0] == '0);
        wr_acc = 1'b1;
      end
      OP_SUB: begin
        result = diff;
        c_next = (acc >= k);
        z_next = (diff == '0);
        wr_acc = 1'b1;
      end
      OP_AND: begin
        result = and_r;
        z_next = (and_r == '0);
        wr_acc = 1'b1;
      end
      OP_NOR: begin
        result = nor_r;
        z_next = (nor_r == '0);
        wr_acc = 1'b1;
      end
      // C=1 means no borrow; the accumulator is left untouched
      OP_CMP: begin
        c_next = (acc >= k);
        z_next = (diff == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/nibble_exec.sv
// Execute/control stage for the nibble ISA: fetches from the program ROM, steers
// the upstream PC, runs the ALU and the two stream handshakes; two cycles per op.
module nibble_exec
  import nibble_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2*DW-1:0] prog_byte,
  output logic            pc_en,
  output logic            pc_load,
  output logic [AW-1:0]   pc_addr,
  nibble_exec_if.slave    io,
  output logic [DW-1:0]   acc,
  output logic            flag_c,
  output logic            flag_z,
  output logic            halted
);

  state_e            state_q,     state_d;
  logic [2*DW-1:0]   ir_q,        ir_d;
  logic [DW-1:0]     acc_q,       acc_d;
  logic              c_q,         c_d;
  logic              z_q,         z_d;
  logic [DW-1:0]     out_data_q,  out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q,  in_ready_d;
  logic              halted_q,    halted_d;

  logic [DW-1:0] op;
  logic [DW-1:0] k;
  logic [DW-1:0] fetch_op;
  logic [DW-1:0] alu_result;
  logic          alu_c;
  logic          alu_z;
  logic          alu_wr_acc;

  assign op       = ir_q[2*DW-1 -: DW];
  assign k        = ir_q[DW-1:0];
  assign fetch_op = prog_byte[2*DW-1 -: DW];

  nibble_alu #(.DW(DW)) u_alu (
    .op     (op),
    .acc    (acc_q),
    .k      (k),
    .c      (c_q),
    .z      (z_q),
    .result (alu_result),
    .c_next (alu_c),
    .z_next (alu_z),
    .wr_acc (alu_wr_acc)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    c_d         = c_q;
    z_d         = z_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    halted_d    = halted_q;

    case (state_q)
      S_FETCH: begin
        ir_d    = prog_byte;
        state_d = S_EXEC;
        // Arm the handshake one cycle early so valid/ready come straight from flops in EXEC.
        if (fetch_op == OP_OUT) begin
          out_data_d  = acc_q;
          out_valid_d = 1'b1;
        end
        if (fetch_op == OP_IN) begin
          in_ready_d = 1'b1;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        if (alu_wr_acc) begin
          acc_d = alu_result;
        end
        c_d = alu_c;
        z_d = alu_z;
        case (op)
          OP_OUT: begin
            if (io.out_ready) out_valid_d = 1'b0;
            else              state_d     = S_WAIT_OUT;
          end
          OP_IN: begin
            if (io.in_valid) begin
              acc_d      = io.in_data;
              z_d        = (io.in_data == '0);
              in_ready_d = 1'b0;
            end else begin
              state_d = S_WAIT_IN;
            end
          end
          OP_HALT: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          default: ;
        endcase
      end

      S_WAIT_OUT: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_FETCH;
        end
      end

      S_WAIT_IN: begin
        if (io.in_valid) begin
          acc_d      = io.in_data;
          z_d        = (io.in_data == '0);
          in_ready_d = 1'b0;
          state_d    = S_FETCH;
        end
      end

      S_HALT: ;

      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      ir_q        <= '0;
      acc_q       <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      halted_q    <= halted_d;
    end
  end

  // PC steering is combinational; gating with reset keeps the fetch stage idle
  // while reset is held even though the state register sits at FETCH.
  always_comb begin
    pc_en   = 1'b0;
    pc_load = 1'b0;
    if (reset) begin
      if (state_q == S_FETCH) begin
        pc_en = 1'b1;
      end else if (state_q == S_EXEC && is_jump(op)) begin
        if (jump_taken(op, c_q, z_q)) pc_load = 1'b1;
        else                          pc_en   = 1'b1;
      end
    end
  end

  // In EXEC the ROM already presents the byte after the opcode: the target low byte.
  assign pc_addr = {k, prog_byte};

  assign io.out_data  = out_data_q;
  assign io.out_valid = out_valid_q;
  assign io.in_ready  = in_ready_q;

  assign acc    = acc_q;
  assign flag_c = c_q;
  assign flag_z = z_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_nibble_exec.sv
// Directed bench for nibble_exec: a program ROM plus PC model stands in for the
// fetch stage; each task runs a short program and checks hand-computed values.
module tb_nibble_exec;
  import nibble_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  prog_byte;
  logic        pc_en;
  logic        pc_load;
  logic [11:0] pc_addr;
  logic [3:0]  acc;
  logic        flag_c;
  logic        flag_z;
  logic        halted;

  logic [7:0]  rom [0:4095];
  logic [11:0] pc;

  int vectors;
  int miscompares;

  nibble_exec_if #(.DW(4)) io ();

  nibble_exec #(.DW(4), .AW(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .prog_byte (prog_byte),
    .pc_en     (pc_en),
    .pc_load   (pc_load),
    .pc_addr   (pc_addr),
    .io        (io),
    .acc       (acc),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream fetch stage: load has priority over increment.
  assign prog_byte = rom[pc];
  always @(posedge clk or negedge reset) begin
    if (!reset)       pc <= 12'h000;
    else if (pc_load) pc <= pc_addr;
    else if (pc_en)   pc <= pc + 12'h001;
  end

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = 4'h0;
    io.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    clear_rom();
    rom[0] = 8'h13;
    rom[1] = 8'h24;
    reset        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = 4'h0;
    io.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (pc_en !== 1'b0) begin miscompares++; $display("FAIL rst_pc_en: got %b want 0", pc_en); end
    vectors++; if (pc_load !== 1'b0) begin miscompares++; $display("FAIL rst_pc_load: got %b want 0", pc_load); end
    vectors++; if (io.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", io.in_ready); end
    vectors++; if (io.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", io.out_valid); end
    vectors++; if ({acc, flag_c, flag_z, halted} !== 7'b0) begin miscompares++; $display("FAIL rst_state: got acc=%h c=%b z=%b h=%b want all 0", acc, flag_c, flag_z, halted); end
    vectors++; if (io.out_data !== 4'h0) begin miscompares++; $display("FAIL rst_out_data: got %h want 0", io.out_data); end
    io.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (pc_en !== pat[i]) begin miscompares++; $display("FAIL pc_en_pattern[%0d]: got %b want %b", i, pc_en, pat[i]); end
      @(negedge clk);
    end
    vectors++; if (acc !== 4'h7) begin miscompares++; $display("FAIL lit_add_acc: got %h want 7", acc); end
    vectors++; if ({flag_c, flag_z} !== 2'b00) begin miscompares++; $display("FAIL lit_add_flags: got c=%b z=%b want 0 0", flag_c, flag_z); end
  endtask

  task automatic test_arith();
    clear_rom();
    rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h31; rom[3] = 8'h6F;
    do_reset();
    repeat (4) @(negedge clk);
    vectors++; if ({acc, flag_c, flag_z} !== {4'h0, 1'b1, 1'b1}) begin miscompares++; $display("FAIL add_15_1: got acc=%h c=%b z=%b want 0 1 1", acc, flag_c, flag_z); end
    repeat (2) @(negedge clk);
    vectors++; if ({acc, flag_c, flag_z} !== {4'hF, 1'b0, 1'b0}) begin miscompares++; $display("FAIL sub_0_1: got acc=%h c=%b z=%b want f 0 0", acc, flag_c, flag_z); end
    repeat (2) @(negedge clk);
    vectors++; if ({acc, flag_c, flag_z} !== {4'hF, 1'b1, 1'b1}) begin miscompares++; $display("FAIL cmp_15_15: got acc=%h c=%b z=%b want f 1 1", acc, flag_c, flag_z); end
  endtask

  task automatic test_logic();
    clear_rom();
    rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h1C;
    rom[3] = 8'h4A; rom[4] = 8'h53; rom[5] = 8'h5F;
    do_reset();
    repeat (8) @(negedge clk);
    vectors++; if ({acc, flag_c, flag_z} !== {4'h8, 1'b1, 1'b0}) begin miscompares++; $display("FAIL and_c_a: got acc=%h c=%b z=%b want 8 1 0", acc, flag_c, flag_z); end
    repeat (2) @(negedge clk);
    vectors++; if ({acc, flag_c, flag_z} !== {4'h4, 1'b1, 1'b0}) begin miscompares++; $display("FAIL nor_8_3: got acc=%h c=%b z=%b want 4 1 0", acc, flag_c, flag_z); end
    repeat (2) @(negedge clk);
    vectors++; if ({acc, flag_c, flag_z} !== {4'h0, 1'b1, 1'b1}) begin miscompares++; $display("FAIL nor_to_zero: got acc=%h c=%b z=%b want 0 1 1", acc, flag_c, flag_z); end
  endtask

  task automatic test_jumps();
    // JZ taken: ADD 0 leaves Z=1
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h20; rom[2] = 8'h9A; rom[3] = 8'h34;
    rom[12'hA34] = 8'hE0;
    do_reset();
    repeat (5) @(negedge clk);
    vectors++; if ({pc_load, pc_en} !== 2'b10) begin miscompares++; $display("FAIL jz_taken_ctl: got load=%b en=%b want 1 0", pc_load, pc_en); end
    vectors++; if (pc_addr !== 12'hA34) begin miscompares++; $display("FAIL jz_taken_addr: got %h want a34", pc_addr); end
    @(negedge clk);
    vectors++; if (pc !== 12'hA34) begin miscompares++; $display("FAIL jz_taken_pc: got %h want a34", pc); end
    // JZ not taken: 1+1 leaves Z=0, low byte skipped
    clear_rom();
    rom[0] = 8'h11; rom[1] = 8'h21; rom[2] = 8'h9A; rom[3] = 8'h34;
    do_reset();
    repeat (5) @(negedge clk);
    vectors++; if ({pc_load, pc_en} !== 2'b01) begin miscompares++; $display("FAIL jz_not_taken_ctl: got load=%b en=%b want 0 1", pc_load, pc_en); end
    @(negedge clk);
    vectors++; if (pc !== 12'h004) begin miscompares++; $display("FAIL jz_not_taken_pc: got %h want 004", pc); end
    // JMP to the top of the address space
    clear_rom();
    rom[0] = 8'hBF; rom[1] = 8'hFF;
    do_reset();
    @(negedge clk);
    vectors++; if ({pc_load, pc_en, pc_addr} !== {2'b10, 12'hFFF}) begin miscompares++; $display("FAIL jmp_fff: got load=%b en=%b addr=%h want 1 0 fff", pc_load, pc_en, pc_addr); end
  endtask

  task automatic test_out_wait();
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'hC0; rom[2] = 8'h17;
    do_reset();
    repeat (3) @(negedge clk);
    vectors++; if ({io.out_valid, io.out_data, pc_en} !== {1'b1, 4'h5, 1'b0}) begin miscompares++; $display("FAIL out_exec: got v=%b d=%h en=%b want 1 5 0", io.out_valid, io.out_data, pc_en); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if ({io.out_valid, io.out_data, pc_en} !== {1'b1, 4'h5, 1'b0}) begin miscompares++; $display("FAIL out_wait[%0d]: got v=%b d=%h en=%b want 1 5 0", i, io.out_valid, io.out_data, pc_en); end
    end
    io.out_ready = 1'b1;
    @(negedge clk);
    vectors++; if ({io.out_valid, pc_en} !== 2'b01) begin miscompares++; $display("FAIL out_accepted: got v=%b en=%b want 0 1", io.out_valid, pc_en); end
    io.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (acc !== 4'h7) begin miscompares++; $display("FAIL out_resume_acc: got %h want 7", acc); end
  endtask

  task automatic test_in_wait();
    clear_rom();
    rom[0] = 8'h19; rom[1] = 8'hD0;
    do_reset();
    repeat (3) @(negedge clk);
    vectors++; if ({io.in_ready, acc} !== {1'b1, 4'h9}) begin miscompares++; $display("FAIL in_exec: got rdy=%b acc=%h want 1 9", io.in_ready, acc); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if ({io.in_ready, pc_en} !== 2'b10) begin miscompares++; $display("FAIL in_wait[%0d]: got rdy=%b en=%b want 1 0", i, io.in_ready, pc_en); end
    end
    io.in_valid = 1'b1;
    io.in_data  = 4'h0;
    @(negedge clk);
    io.in_valid = 1'b0;
    vectors++; if ({io.in_ready, acc, flag_z, pc_en} !== {1'b0, 4'h0, 1'b1, 1'b1}) begin miscompares++; $display("FAIL in_accepted: got rdy=%b acc=%h z=%b en=%b want 0 0 1 1", io.in_ready, acc, flag_z, pc_en); end
  endtask

  task automatic test_back_to_back();
    clear_rom();
    rom[0] = 8'hD0; rom[1] = 8'hC0; rom[2] = 8'h2A;
    do_reset();
    io.in_valid  = 1'b1;
    io.in_data   = 4'h6;
    io.out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (io.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready: got %b want 1", io.in_ready); end
    @(negedge clk);
    io.in_valid = 1'b0;
    vectors++; if ({io.in_ready, acc, pc_en} !== {1'b0, 4'h6, 1'b1}) begin miscompares++; $display("FAIL b2b_in_done: got rdy=%b acc=%h en=%b want 0 6 1", io.in_ready, acc, pc_en); end
    @(negedge clk);
    vectors++; if ({io.out_valid, io.out_data} !== {1'b1, 4'h6}) begin miscompares++; $display("FAIL b2b_out: got v=%b d=%h want 1 6", io.out_valid, io.out_data); end
    @(negedge clk);
    vectors++; if ({io.out_valid, pc_en} !== 2'b01) begin miscompares++; $display("FAIL b2b_out_done: got v=%b en=%b want 0 1", io.out_valid, pc_en); end
    @(negedge clk);
    @(negedge clk);
    vectors++; if ({acc, flag_c, flag_z} !== {4'h0, 1'b1, 1'b1}) begin miscompares++; $display("FAIL b2b_add_6_a: got acc=%h c=%b z=%b want 0 1 1", acc, flag_c, flag_z); end
    io.out_ready = 1'b0;
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0] = 8'hE0; rom[1] = 8'h15;
    do_reset();
    repeat (2) @(negedge clk);
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_flag: got %b want 1", halted); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if ({pc_en, pc_load, io.in_ready, io.out_valid, halted} !== 5'b00001) begin miscompares++; $display("FAIL halt_idle[%0d]: got en=%b ld=%b rdy=%b v=%b h=%b want 0 0 0 0 1", i, pc_en, pc_load, io.in_ready, io.out_valid, halted); end
    end
    vectors++; if (acc !== 4'h0) begin miscompares++; $display("FAIL halt_acc: got %h want 0", acc); end
  endtask

  task automatic test_reset_wait_out();
    clear_rom();
    rom[0] = 8'h13; rom[1] = 8'hC0;
    do_reset();
    repeat (4) @(negedge clk);
    vectors++; if (io.out_valid !== 1'b1) begin miscompares++; $display("FAIL rwo_waiting: got v=%b want 1", io.out_valid); end
    #2;
    reset = 1'b0;
    #1;
    vectors++; if ({io.out_valid, acc, pc_en, pc_load} !== {1'b0, 4'h0, 1'b0, 1'b0}) begin miscompares++; $display("FAIL rwo_async: got v=%b acc=%h en=%b ld=%b want 0 0 0 0", io.out_valid, acc, pc_en, pc_load); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++; if ({pc_en, io.out_valid, pc} !== {1'b1, 1'b0, 12'h000}) begin miscompares++; $display("FAIL rwo_fetch: got en=%b v=%b pc=%h want 1 0 000", pc_en, io.out_valid, pc); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_arith();
    test_logic();
    test_jumps();
    test_out_wait();
    test_in_wait();
    test_back_to_back();
    test_halt();
    test_reset_wait_out();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
